// File: rtl/freq_pkg.sv
// Shared constants, FSM state type and BCD helper for the freq_gen block.
package freq_pkg;

  localparam int CLK_FRE_DEF = 27_000_000;
  localparam int DIG_W       = 4;
  localparam int DIV_W       = 15;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DIV,
    APPLY
  } state_t;

  function automatic int bcd2bin(input logic [15:0] b);
    return int'(b[15:12]) * 1000 + int'(b[11:8]) * 100
         + int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

endpackage

// File: rtl/freq_div_seq.sv
// Iterative restoring divider: one quotient bit per cycle, N cycles start->done.
module freq_div_seq
  import freq_pkg::*;
#(
  parameter int N = 26,
  parameter int D = DIV_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [D-1:0] divisor,
  output logic         done,
  output logic [N-1:0] quot
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [N-1:0]  qr;
  logic [D-1:0]  rem;
  logic [D-1:0]  dv;
  logic [CW-1:0] cnt;
  logic          busy;
  logic [D:0]    trial;
  logic [D:0]    diff;
  logic          ge;

  assign trial = {rem, qr[N-1]};
  assign diff  = trial - {1'b0, dv};
  assign ge    = trial >= {1'b0, dv};
  assign done  = busy && (cnt == LAST);
  assign quot  = qr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      qr   <= '0;
      rem  <= '0;
      dv   <= '0;
      cnt  <= '0;
      busy <= 1'b0;
    end else if (start) begin
      qr   <= dividend;
      rem  <= '0;
      dv   <= divisor;
      cnt  <= '0;
      busy <= 1'b1;
    end else if (busy) begin
      // remainder stays below divisor, so trial's top bit is 0 when !ge
      rem  <= ge ? diff[D-1:0] : trial[D-1:0];
      qr   <= {qr[N-2:0], ge};
      cnt  <= cnt + CW'(1);
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/freq_gen.sv
// Programmable BCD-set square-wave generator with handshake load.
// Define FREQ_GEN_SYNC_APPLY_EN to defer new periods to the next terminal count.
module freq_gen
  import freq_pkg::*;
#(
  parameter int          CLK_FRE      = CLK_FRE_DEF,
  parameter int          CNT_W        = 26,
  parameter logic [15:0] DEF_FREQ_BCD = 16'h1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [15:0] freq_bcd,
  input  logic        enable,
  output logic        sig_out,
  output logic [15:0] cur_freq_bcd,
  output logic        err
);

  localparam logic [CNT_W-1:0] DEF_HALF =
    CNT_W'(CLK_FRE / (2 * bcd2bin(DEF_FREQ_BCD)));
  localparam logic [CNT_W-1:0] DIVIDEND = CNT_W'(CLK_FRE);

  state_t           state, nxt;
  logic [15:0]      dig;
  logic [15:0]      conv_sh;
  logic [1:0]       idx;
  logic [13:0]      bin;
  logic [13:0]      bin_nx;
  logic             bad;
  logic             accept;
  logic             start;
  logic             apply;
  logic             done;
  logic [CNT_W-1:0] quot;
  logic [CNT_W-1:0] half;
  logic [CNT_W-1:0] cnt;
  logic             tc;

  assign load_ready = (state == IDLE);
  assign accept     = load_valid && load_ready;
  assign bad = (freq_bcd[15:12] > 4'd9) || (freq_bcd[11:8] > 4'd9)
            || (freq_bcd[7:4] > 4'd9) || (freq_bcd[3:0] > 4'd9)
            || (freq_bcd == '0);
  assign bin_nx = 14'(bin * 14'd10) + {10'd0, conv_sh[15:12]};

  always_comb begin
    nxt   = state;
    start = 1'b0;
    apply = 1'b0;
    unique case (state)
      IDLE:  if (accept && !bad) nxt = CONV;
      CONV:  if (idx == 2'd3) begin
               nxt   = DIV;
               start = 1'b1;
             end
      DIV:   if (done) nxt = APPLY;
      APPLY: begin
               nxt   = IDLE;
               apply = 1'b1;
             end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dig          <= '0;
      conv_sh      <= '0;
      idx          <= '0;
      bin          <= '0;
      err          <= 1'b0;
      cur_freq_bcd <= DEF_FREQ_BCD;
    end else begin
      if (accept) begin
        if (bad) begin
          err <= 1'b1;
        end else begin
          err     <= 1'b0;
          dig     <= freq_bcd;
          conv_sh <= freq_bcd;
          idx     <= '0;
          bin     <= '0;
        end
      end
      if (state == CONV) begin
        bin     <= bin_nx;
        conv_sh <= {conv_sh[11:0], 4'h0};
        idx     <= idx + 2'd1;
      end
      if (apply) cur_freq_bcd <= dig;
    end
  end

  // divisor is taken from the final conversion step so DIV starts at once
  freq_div_seq #(
    .N (CNT_W),
    .D (DIV_W)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .dividend (DIVIDEND),
    .divisor  ({bin_nx, 1'b0}),
    .done     (done),
    .quot     (quot)
  );

  assign tc = (cnt == half - CNT_W'(1));

`ifdef FREQ_GEN_SYNC_APPLY_EN
  logic [CNT_W-1:0] pend;
  logic             pend_vld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      half     <= DEF_HALF;
      cnt      <= '0;
      sig_out  <= 1'b0;
      pend     <= '0;
      pend_vld <= 1'b0;
    end else begin
      if (!enable) begin
        cnt     <= '0;
        sig_out <= 1'b0;
        if (pend_vld) begin
          half     <= pend;
          pend_vld <= 1'b0;
        end
      end else if (tc) begin
        cnt     <= '0;
        sig_out <= ~sig_out;
        if (pend_vld) begin
          half     <= pend;
          pend_vld <= 1'b0;
        end
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      // a fresh result overrides any adoption in the same cycle
      if (apply) begin
        pend     <= quot;
        pend_vld <= 1'b1;
      end
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      half    <= DEF_HALF;
      cnt     <= '0;
      sig_out <= 1'b0;
    end else if (apply) begin
      half    <= quot;
      cnt     <= '0;
      sig_out <= 1'b0;
    end else if (!enable) begin
      cnt     <= '0;
      sig_out <= 1'b0;
    end else if (tc) begin
      cnt     <= '0;
      sig_out <= ~sig_out;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_freq_gen.sv
// Self-checking bench for freq_gen: behavioural model plus directed and random loads.
module tb_freq_gen;

  localparam int CLK = 27_000_000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [15:0] freq_bcd = '0;
  logic        enable = 1'b0;
  logic        sig_out;
  logic [15:0] cur_freq_bcd;
  logic        err;

  int errors = 0;
  int checks = 0;

  int          ecount = 0;
  int          rs = 0;
  int          half_m = 13500;
  int          apply_e = 0;
  int          pend_half = 0;
  bit          busy = 0;
  bit          err_m = 0;
  bit          sig_m = 0;
  logic [15:0] cur_m = 16'h1000;
  logic [15:0] pend_bcd = '0;

  freq_gen dut (
    .clk          (clk),
    .rst          (rst),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .freq_bcd     (freq_bcd),
    .enable       (enable),
    .sig_out      (sig_out),
    .cur_freq_bcd (cur_freq_bcd),
    .err          (err)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit bcd_ok(input logic [15:0] b);
    if (b[15:12] > 9 || b[11:8] > 9 || b[7:4] > 9 || b[3:0] > 9) return 0;
    return b != 16'h0000;
  endfunction

  function automatic int bcd_val(input logic [15:0] b);
    return b[15:12] * 1000 + b[11:8] * 100 + b[7:4] * 10 + b[3:0];
  endfunction

  // Model: waveform phase is (enabled edges since last restart) / half.
  always @(posedge clk) begin : model_p
    bit rdy;
    ecount++;
    if (rst) begin
      half_m = 13500;
      cur_m  = 16'h1000;
      err_m  = 0;
      busy   = 0;
      rs     = ecount;
    end else begin
      rdy = !busy;
      if (busy && ecount == apply_e) begin
        half_m = pend_half;
        cur_m  = pend_bcd;
        busy   = 0;
        rs     = ecount;
      end else if (!enable) begin
        rs = ecount;
      end
      if (rdy && load_valid) begin
        if (!bcd_ok(freq_bcd)) begin
          err_m = 1;
        end else begin
          err_m     = 0;
          busy      = 1;
          apply_e   = ecount + 31;
          pend_bcd  = freq_bcd;
          pend_half = CLK / (2 * bcd_val(freq_bcd));
        end
      end
    end
    sig_m = (((ecount - rs) / half_m) % 2) == 1;
  end

  always @(posedge clk) begin
    #1;
    cmp("sig_out", {31'd0, sig_out}, {31'd0, sig_m});
    cmp("load_ready", {31'd0, load_ready}, {31'd0, !busy});
    cmp("err", {31'd0, err}, {31'd0, err_m});
    cmp("cur_freq_bcd", {16'd0, cur_freq_bcd}, {16'd0, cur_m});
  end

  task automatic load(input logic [15:0] b);
    @(negedge clk);
    freq_bcd   = b;
    load_valid = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!load_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic count_high(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sig_out && n < 20000);
  endtask

  initial begin
    int n;
    bit seen;
    logic [15:0] b;

    enable = 1'b1;
    repeat (3) @(negedge clk);
    cmp("rst_cur", {16'd0, cur_freq_bcd}, 32'h1000);
    cmp("rst_ready", {31'd0, load_ready}, 32'd1);
    cmp("rst_sig", {31'd0, sig_out}, 32'd0);
    cmp("rst_err", {31'd0, err}, 32'd0);

    rst = 1'b0;
    count_high(n);
    cmp("first_toggle_1000hz", n, 13500);

    load(16'h9999);
    cmp("model_half_9999", pend_half, 1350);
    wait_ready(n);
    cmp("busy_cycles_9999", n, 31);
    cmp("cur_9999", {16'd0, cur_freq_bcd}, 32'h9999);
    repeat (3000) @(negedge clk);

    load(16'h12A4);
    cmp("err_bad_digit", {31'd0, err}, 32'd1);
    cmp("ready_bad_digit", {31'd0, load_ready}, 32'd1);
    load(16'h0000);
    cmp("err_zero", {31'd0, err}, 32'd1);
    cmp("cur_after_rejects", {16'd0, cur_freq_bcd}, 32'h9999);
    load(16'h0050);
    cmp("err_cleared", {31'd0, err}, 32'd0);
    cmp("model_half_50", pend_half, 270000);
    wait_ready(n);
    cmp("ready_timeout_50", n, 31);
    cmp("cur_0050", {16'd0, cur_freq_bcd}, 32'h0050);
    repeat (500) @(negedge clk);

    load(16'h5000);
    repeat (8) @(negedge clk);
    freq_bcd   = 16'h0002;
    load_valid = 1'b1;
    repeat (15) @(negedge clk);
    load_valid = 1'b0;
    wait_ready(n);
    cmp("ready_timeout_busy", {31'd0, n < 100}, 32'd1);
    cmp("cur_busy_ignored", {16'd0, cur_freq_bcd}, 32'h5000);
    repeat (6000) @(negedge clk);

    enable = 1'b0;
    seen = 0;
    repeat (5000) begin
      @(negedge clk);
      if (sig_out) seen = 1;
    end
    cmp("disabled_low", {31'd0, seen}, 32'd0);
    enable = 1'b1;
    count_high(n);
    cmp("reenable_first_rise", n, 2700);

    load(16'h9999);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    cmp("midload_rst_cur", {16'd0, cur_freq_bcd}, 32'h1000);
    cmp("midload_rst_ready", {31'd0, load_ready}, 32'd1);
    rst = 1'b0;
    count_high(n);
    cmp("resume_1000hz", n, 13500);

    for (int it = 0; it < 25; it++) begin
      if ($urandom_range(0, 4) == 0) enable = ~enable;
      else enable = 1'b1;
      if ($urandom_range(0, 9) < 7) begin
        b[15:12] = 4'($urandom_range(5, 9));
        b[11:8]  = 4'($urandom_range(0, 9));
        b[7:4]   = 4'($urandom_range(0, 9));
        b[3:0]   = 4'($urandom_range(0, 9));
      end else begin
        b = 16'($urandom);
      end
      @(negedge clk);
      freq_bcd   = b;
      load_valid = 1'b1;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      load_valid = 1'b0;
      repeat ($urandom_range(20, 600)) @(negedge clk);
    end

    enable = 1'b1;
    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
